// File: rtl/dec_stage_pkg.sv
// dec_stage_pkg: shared decode definitions for the multi-thread decode stage.
//   - opcode constants (ins[3:0]); funct lives in ins[11:9]
//   - jmp_con / trd_ctrl encodings
//   - dec_t: registered control bundle presented to execute
//   - decode_ins(): pure instruction -> dec_t mapping, including legality
//
// Instruction field map:
//   [31:27] rd / store-data / branch-compare reg   [26:22] rs_a
//   [21:17] rs_b   [27:12] imm16   [11:9] funct   [8] MEMOP load(1)/store(0)
//   [6:5] EXC kind   [4] SHIFT immediate-amount   [3:0] opcode
package dec_stage_pkg;

   localparam logic [3:0] OP_CAL    = 4'h0;
   localparam logic [3:0] OP_CALI   = 4'h1;
   localparam logic [3:0] OP_SHIFT  = 4'h2;
   localparam logic [3:0] OP_LOADI  = 4'h3;
   localparam logic [3:0] OP_MEMOP  = 4'h4;
   localparam logic [3:0] OP_BRANCH = 4'h5;
   localparam logic [3:0] OP_EXC    = 4'h6;
   localparam logic [3:0] OP_MULTI  = 4'h7;

   // jmp_con: MSB marks a branch, low bits carry the condition (funct).
   localparam logic [3:0] JC_NONE = 4'b0000;
   localparam logic [3:0] JC_EQ   = 4'b1000;
   localparam logic [3:0] JC_NE   = 4'b1001;
   localparam logic [3:0] JC_LT   = 4'b1010;
   localparam logic [3:0] JC_GE   = 4'b1011;
   localparam logic [3:0] JC_AL   = 4'b1111;

   // trd_ctrl: MULTI funct passed through for the legal subset.
   localparam logic [2:0] TC_NONE  = 3'b000;   // thread fence, no side effect
   localparam logic [2:0] TC_SLEEP = 3'b010;
   localparam logic [2:0] TC_KILL  = 3'b101;
   localparam logic [2:0] TC_SPAWN = 3'b111;   // writes new thread id to rd

   localparam logic [1:0] MEM_NONE  = 2'b00;
   localparam logic [1:0] MEM_LOAD  = 2'b01;
   localparam logic [1:0] MEM_STORE = 2'b10;

   typedef struct packed {
      logic [4:0]  reg_rd_a;
      logic [4:0]  reg_rd_b;
      logic [4:0]  reg_wr;
      logic [15:0] imm;
      logic        wr_en;
      logic [2:0]  alu_op;
      logic [1:0]  mem_ctrl;
      logic [2:0]  trd_ctrl;
      logic        wb_sel;
      logic        init;
      logic        exp_jmp;
      logic        exp_return;
      logic [3:0]  jmp_con;
      logic        invalid;
      logic        i_type;
   } dec_t;

   function automatic dec_t decode_ins(input logic [31:0] ins);
      dec_t       d;
      logic [2:0] funct;
      logic       bad;
      d          = '0;
      bad        = 1'b0;
      funct      = ins[11:9];
      d.reg_rd_a = ins[26:22];
      d.reg_rd_b = ins[21:17];
      d.reg_wr   = ins[31:27];
      d.imm      = ins[27:12];
      case (ins[3:0])
         OP_CAL: begin
            d.wr_en  = 1'b1;
            d.alu_op = funct;
         end
         OP_CALI: begin
            d.wr_en  = 1'b1;
            d.alu_op = funct;
            d.i_type = 1'b1;
         end
         OP_SHIFT: begin
            d.wr_en  = 1'b1;
            d.alu_op = funct;
            d.i_type = ins[4];
         end
         OP_LOADI: begin
            d.wr_en    = 1'b1;
            d.i_type   = 1'b1;
            d.reg_rd_b = ins[31:27];
         end
         OP_MEMOP: begin
            d.reg_rd_b = ins[31:27];
            d.i_type   = 1'b1;
            d.mem_ctrl = ins[8] ? MEM_LOAD : MEM_STORE;
            d.wb_sel   = ins[8];
            d.wr_en    = ins[8];
         end
         OP_BRANCH: begin
            d.reg_rd_b = ins[31:27];
            d.i_type   = 1'b1;
            if (funct inside {3'b100, 3'b101, 3'b110}) bad = 1'b1;
            else d.jmp_con = {1'b1, funct};
         end
         OP_EXC: begin
            case (ins[6:5])
               2'b00:   bad          = 1'b1;
               2'b10:   d.exp_return = 1'b1;
               default: d.exp_jmp    = 1'b1;
            endcase
         end
         OP_MULTI: begin
            if (funct inside {3'b001, 3'b011, 3'b100, 3'b110}) bad = 1'b1;
            else begin
               d.trd_ctrl = funct;
               if (funct == TC_SPAWN) begin
                  d.init  = 1'b1;
                  d.wr_en = 1'b1;
               end
            end
         end
         default: bad = 1'b1;
      endcase
      // An illegal instruction must not leak any side-effecting control.
      if (bad) begin
         d         = '0;
         d.invalid = 1'b1;
      end
      return d;
   endfunction

endpackage

// File: rtl/dec_stage_trd_ins_fifo.sv
// trd_ins_fifo: per-thread instruction queue.
//   clk, rst   : clock, synchronous active-high reset
//   clr_i      : synchronous clear (flush), highest priority after reset
//   push_i     : write din_i at tail (accepted when not full, or when full
//                with a same-cycle pop)
//   pop_i      : drop head (ignored when empty)
//   dout_o     : head entry; count_o / full_o / empty_o : occupancy
module trd_ins_fifo #(
   parameter int DEPTH = 2,
   parameter int W     = 32
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic [W-1:0]           din_i,
   output logic [W-1:0]           dout_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   full_o,
   output logic                   empty_o
);
   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [W-1:0]  mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [AW:0]   cnt_q;
   logic          do_push, do_pop;

   assign empty_o = (cnt_q == '0);
   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign count_o = cnt_q;
   assign dout_o  = mem_q[rd_ptr_q];

   assign do_pop  = pop_i && !empty_o;
   assign do_push = push_i && (!full_o || do_pop);

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst || clr_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         case ({do_push, do_pop})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // Storage carries no reset; stale entries are never visible past count.
   always_ff @(posedge clk) begin
      if (do_push && !clr_i) mem_q[wr_ptr_q] <= din_i;
   end

endmodule

// File: rtl/dec_stage.sv
// dec_stage: multi-thread decode stage between fetch and execute.
//   Fetch side : in_valid/in_ready handshake, in_trd selects the queue,
//                q_count reports per-thread occupancy (CNT_W bits each).
//   Control    : trd_active masks threads from arbitration; flush_en/flush_trd
//                empty one thread's queue and drop its registered bundle.
//   Execute    : out_valid/out_ready handshake with out_trd and decoded out_dec.
// One round-robin grant per cycle feeds a single output register.
module dec_stage
   import dec_stage_pkg::*;
#(
   parameter int NUM_TRD = 4,
   parameter int DEPTH   = 2,
   parameter int TID_W   = $clog2(NUM_TRD)
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic                                 in_valid,
   input  logic [TID_W-1:0]                     in_trd,
   input  logic [31:0]                          in_ins,
   output logic                                 in_ready,
   input  logic [NUM_TRD-1:0]                   trd_active,
   input  logic                                 flush_en,
   input  logic [TID_W-1:0]                     flush_trd,
   output logic                                 out_valid,
   input  logic                                 out_ready,
   output logic [TID_W-1:0]                     out_trd,
   output dec_t                                 out_dec,
   output logic [NUM_TRD*($clog2(DEPTH)+1)-1:0] q_count
);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [NUM_TRD-1:0]       push, pop, clr, full, empty, elig;
   logic [NUM_TRD-1:0][31:0] head;
   logic [TID_W-1:0]         rr_ptr_q, rr_ptr_d, grant;
   logic                     grant_vld, load;
   logic                     out_valid_q, out_valid_d;
   logic [TID_W-1:0]         out_trd_q, out_trd_d;
   dec_t                     out_dec_q, out_dec_d;

   // A flush of the addressed thread wins over the push, so refuse it here.
   assign in_ready = !full[in_trd] && !(flush_en && (flush_trd == in_trd));

   for (genvar t = 0; t < NUM_TRD; t++) begin : g_q
      assign clr[t]  = flush_en && (flush_trd == TID_W'(t));
      assign push[t] = in_valid && in_ready && (in_trd == TID_W'(t));
      assign pop[t]  = load && (grant == TID_W'(t));
      assign elig[t] = !empty[t] && trd_active[t] && !clr[t];

      trd_ins_fifo #(.DEPTH(DEPTH), .W(32)) u_q (
         .clk     (clk),
         .rst     (rst),
         .clr_i   (clr[t]),
         .push_i  (push[t]),
         .pop_i   (pop[t]),
         .din_i   (in_ins),
         .dout_o  (head[t]),
         .count_o (q_count[t*CNT_W +: CNT_W]),
         .full_o  (full[t]),
         .empty_o (empty[t])
      );
   end

   // Round-robin: scan from rr_ptr, wrapping mod NUM_TRD, first eligible wins.
   always_comb begin
      logic [TID_W-1:0] idx;
      grant     = '0;
      grant_vld = 1'b0;
      idx       = '0;
      for (int i = 0; i < NUM_TRD; i++) begin
         idx = rr_ptr_q + TID_W'(i);
         if (!grant_vld && elig[idx]) begin
            grant     = idx;
            grant_vld = 1'b1;
         end
      end
   end

   assign load     = grant_vld && (!out_valid_q || out_ready);
   assign rr_ptr_d = load ? grant + 1'b1 : rr_ptr_q;

   always_comb begin
      out_valid_d = out_valid_q;
      out_trd_d   = out_trd_q;
      out_dec_d   = out_dec_q;
      if (load) begin
         out_valid_d = 1'b1;
         out_trd_d   = grant;
         out_dec_d   = decode_ins(head[grant]);
      end else if (out_ready || (flush_en && (flush_trd == out_trd_q))) begin
         // Consumed, or its thread was flushed even under back-pressure.
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr_q    <= '0;
         out_valid_q <= 1'b0;
         out_trd_q   <= '0;
         out_dec_q   <= '0;
      end else begin
         rr_ptr_q    <= rr_ptr_d;
         out_valid_q <= out_valid_d;
         out_trd_q   <= out_trd_d;
         out_dec_q   <= out_dec_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_trd   = out_trd_q;
   assign out_dec   = out_dec_q;

endmodule

// File: tb/tb_dec_stage.sv
// tb_dec_stage: directed self-checking bench for dec_stage (NUM_TRD=4, DEPTH=2).
// Inputs change on the falling edge; outputs are checked on the falling edge.
module tb_dec_stage;
   import dec_stage_pkg::*;

   localparam int NUM_TRD = 4;
   localparam int DEPTH   = 2;
   localparam int TID_W   = 2;
   localparam int CNT_W   = 2;

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       in_valid;
   logic [TID_W-1:0]           in_trd;
   logic [31:0]                in_ins;
   logic                       in_ready;
   logic [NUM_TRD-1:0]         trd_active;
   logic                       flush_en;
   logic [TID_W-1:0]           flush_trd;
   logic                       out_valid;
   logic                       out_ready;
   logic [TID_W-1:0]           out_trd;
   dec_t                       out_dec;
   logic [NUM_TRD*CNT_W-1:0]   q_count;

   int tests = 0;
   int fails = 0;

   dec_stage #(.NUM_TRD(NUM_TRD), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_trd     (in_trd),
      .in_ins     (in_ins),
      .in_ready   (in_ready),
      .trd_active (trd_active),
      .flush_en   (flush_en),
      .flush_trd  (flush_trd),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_trd    (out_trd),
      .out_dec    (out_dec),
      .q_count    (q_count)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic logic [CNT_W-1:0] qc(input int t);
      return q_count[t*CNT_W +: CNT_W];
   endfunction

   task automatic push(input logic [TID_W-1:0] tid, input logic [31:0] ins);
      in_valid = 1'b1;
      in_trd   = tid;
      in_ins   = ins;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b0; in_trd = '0; in_ins = '0;
      trd_active = '0; flush_en = 1'b0; flush_trd = '0; out_ready = 1'b0;
      repeat (2) @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
      tests++; if (out_trd !== '0) begin fails++; $display("FAIL rst_out_trd got %0d exp 0", out_trd); end
      tests++; if (out_dec !== '0) begin fails++; $display("FAIL rst_out_dec got %h exp 0", out_dec); end
      tests++; if (q_count !== '0) begin fails++; $display("FAIL rst_q_count got %h exp 0", q_count); end
      rst = 1'b0;
      for (int t = 0; t < NUM_TRD; t++) begin
         in_trd = TID_W'(t); #1;
         tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready trd %0d got %b exp 1", t, in_ready); end
      end
   endtask

   task automatic test_latency();
      dec_t exp;
      exp = '0;
      exp.reg_rd_a = 5'd3; exp.reg_rd_b = 5'd5; exp.reg_wr = 5'd5; exp.imm = 16'h8C00;
      exp.wr_en = 1'b1; exp.mem_ctrl = 2'b01; exp.wb_sel = 1'b1; exp.i_type = 1'b1;
      trd_active = 4'b1111; out_ready = 1'b1;
      // MEMOP load: rd=5 in [31:27], rs_a=3, ins[8]=1
      push(2'd2, 32'h28C0_0104);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL lat_early_valid got %b exp 0", out_valid); end
      tests++; if (qc(2) !== 2'd1) begin fails++; $display("FAIL lat_qcount2 got %0d exp 1", qc(2)); end
      @(negedge clk);
      tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL lat_valid got %b exp 1", out_valid); end
      tests++; if (out_trd !== 2'd2) begin fails++; $display("FAIL lat_trd got %0d exp 2", out_trd); end
      tests++; if (out_dec.mem_ctrl !== 2'b01) begin fails++; $display("FAIL lat_mem_ctrl got %b exp 01", out_dec.mem_ctrl); end
      tests++; if (out_dec.wb_sel !== 1'b1 || out_dec.wr_en !== 1'b1) begin fails++; $display("FAIL lat_wb_wr got %b%b exp 11", out_dec.wb_sel, out_dec.wr_en); end
      tests++; if (out_dec.reg_rd_b !== 5'd5) begin fails++; $display("FAIL lat_rd_b got %0d exp 5", out_dec.reg_rd_b); end
      tests++; if (out_dec !== exp) begin fails++; $display("FAIL lat_dec got %h exp %h", out_dec, exp); end
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL lat_consumed got %b exp 0", out_valid); end
   endtask

   task automatic test_full();
      trd_active = 4'b0000; out_ready = 1'b0;
      push(2'd0, 32'h0000_1000);
      push(2'd0, 32'h0000_2000);
      tests++; if (qc(0) !== 2'd2) begin fails++; $display("FAIL full_qcount0 got %0d exp 2", qc(0)); end
      in_valid = 1'b1; in_trd = 2'd0; in_ins = 32'h0000_3000; #1;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL full_in_ready0 got %b exp 0", in_ready); end
      in_trd = 2'd1; #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL full_in_ready1 got %b exp 1", in_ready); end
      in_trd = 2'd0;
      @(negedge clk);
      in_valid = 1'b0;
      tests++; if (qc(0) !== 2'd2) begin fails++; $display("FAIL full_hold_qcount got %0d exp 2", qc(0)); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL full_masked_valid got %b exp 0", out_valid); end
      flush_en = 1'b1; flush_trd = 2'd0;
      @(negedge clk);
      flush_en = 1'b0;
      tests++; if (qc(0) !== 2'd0) begin fails++; $display("FAIL full_flush_qcount got %0d exp 0", qc(0)); end
   endtask

   task automatic test_round_robin();
      int exp_trd [6] = '{0, 1, 3, 0, 1, 3};
      int exp_imm [6] = '{0, 16, 48, 1, 17, 49};
      apply_reset();
      trd_active = 4'b0000; out_ready = 1'b0;
      for (int t = 0; t < NUM_TRD; t++)
         for (int k = 0; k < 2; k++)
            push(TID_W'(t), 32'((t*16 + k) << 12));
      tests++; if (q_count !== 8'hAA) begin fails++; $display("FAIL rr_preload got %h exp aa", q_count); end
      trd_active = 4'b1011; out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         tests++;
         if (out_valid !== 1'b1 || out_trd !== TID_W'(exp_trd[i]) || out_dec.imm !== 16'(exp_imm[i])) begin
            fails++;
            $display("FAIL rr_grant%0d got v=%b trd=%0d imm=%0d exp v=1 trd=%0d imm=%0d",
                     i, out_valid, out_trd, out_dec.imm, exp_trd[i], exp_imm[i]);
         end
      end
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rr_masked_valid got %b exp 0", out_valid); end
      tests++; if (qc(2) !== 2'd2) begin fails++; $display("FAIL rr_masked_keep got %0d exp 2", qc(2)); end
      flush_en = 1'b1; flush_trd = 2'd2;
      @(negedge clk);
      flush_en = 1'b0; trd_active = 4'b1111;
   endtask

   task automatic test_illegal();
      logic [31:0] ins [5] = '{32'hFFFF_0A05, 32'hFFFF_0207, 32'hFFFF_0006, 32'hFFFF_000F, 32'h0000_0E07};
      dec_t exp [5];
      for (int i = 0; i < 4; i++) begin
         exp[i] = '0; exp[i].invalid = 1'b1;
      end
      exp[4] = '0; exp[4].trd_ctrl = 3'b111; exp[4].init = 1'b1; exp[4].wr_en = 1'b1;
      trd_active = 4'b1111; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         push(2'd0, ins[i]);
         @(negedge clk);
         tests++;
         if (out_valid !== 1'b1 || out_dec !== exp[i]) begin
            fails++;
            $display("FAIL illegal_vec%0d ins %h got v=%b dec=%h exp v=1 dec=%h", i, ins[i], out_valid, out_dec, exp[i]);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_flush();
      trd_active = 4'b1111; out_ready = 1'b0;
      push(2'd1, 32'h0000_1000);
      push(2'd1, 32'h0000_2000);
      push(2'd1, 32'h0000_3000);
      tests++; if (out_valid !== 1'b1 || out_trd !== 2'd1) begin fails++; $display("FAIL flush_setup got v=%b trd=%0d exp v=1 trd=1", out_valid, out_trd); end
      tests++; if (qc(1) !== 2'd2) begin fails++; $display("FAIL flush_setup_q got %0d exp 2", qc(1)); end
      @(negedge clk);
      tests++; if (out_valid !== 1'b1 || out_dec.imm !== 16'd1) begin fails++; $display("FAIL hold_stable got v=%b imm=%0d exp v=1 imm=1", out_valid, out_dec.imm); end
      flush_en = 1'b1; flush_trd = 2'd1;
      in_valid = 1'b1; in_trd = 2'd1; in_ins = 32'h0000_4000; #1;
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_in_ready got %b exp 0", in_ready); end
      @(negedge clk);
      flush_en = 1'b0; in_valid = 1'b0;
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_out_valid got %b exp 0", out_valid); end
      tests++; if (qc(1) !== 2'd0) begin fails++; $display("FAIL flush_qcount got %0d exp 0", qc(1)); end
      @(negedge clk);
      tests++; if (out_valid !== 1'b0 || qc(1) !== 2'd0) begin fails++; $display("FAIL flush_push_dropped got v=%b q=%0d exp v=0 q=0", out_valid, qc(1)); end
   endtask

   task automatic test_mid_reset();
      trd_active = 4'b1111; out_ready = 1'b0;
      for (int t = 0; t < NUM_TRD; t++) push(TID_W'(t), 32'h0000_5000);
      push(2'd0, 32'h0000_6000);
      tests++; if (q_count !== 8'h55 || out_valid !== 1'b1) begin fails++; $display("FAIL mid_setup got q=%h v=%b exp q=55 v=1", q_count, out_valid); end
      rst = 1'b1;
      @(negedge clk);
      tests++; if (out_valid !== 1'b0 || out_trd !== '0 || out_dec !== '0) begin fails++; $display("FAIL mid_rst_out got v=%b trd=%0d dec=%h exp all 0", out_valid, out_trd, out_dec); end
      tests++; if (q_count !== '0) begin fails++; $display("FAIL mid_rst_q got %h exp 0", q_count); end
      rst = 1'b0;
      for (int t = 0; t < NUM_TRD; t++) begin
         in_trd = TID_W'(t); #1;
         tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL mid_rst_in_ready trd %0d got %b exp 1", t, in_ready); end
      end
      // rr_ptr back at 0: thread 0 beats thread 2 even though 2 was queued first.
      trd_active = 4'b0000;
      push(2'd2, 32'h0000_7000);
      push(2'd0, 32'h0000_8000);
      trd_active = 4'b1111; out_ready = 1'b1;
      @(negedge clk);
      tests++; if (out_valid !== 1'b1 || out_trd !== 2'd0) begin fails++; $display("FAIL mid_rr_first got v=%b trd=%0d exp v=1 trd=0", out_valid, out_trd); end
      @(negedge clk);
      tests++; if (out_valid !== 1'b1 || out_trd !== 2'd2) begin fails++; $display("FAIL mid_rr_second got v=%b trd=%0d exp v=1 trd=2", out_valid, out_trd); end
   endtask

   initial begin
      test_reset();
      test_latency();
      test_full();
      test_round_robin();
      test_illegal();
      test_flush();
      test_mid_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
